// File: rtl/id_stage_pkg.sv
// Shared widths, opcode constants, ALU encodings and bus layouts for the LA32R decode stage.
// Bus structs are packed so they cast directly to and from the flat port vectors.
package id_stage_pkg;

    localparam int FS_DS_BUS_WD  = 64;
    localparam int DS_ES_BUS_WD  = 139;
    localparam int BR_BUS_WD     = 34;
    localparam int ES_FWD_BUS_WD = 39;
    localparam int MS_FWD_BUS_WD = 38;
    localparam int WS_RF_BUS_WD  = 38;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_PASSB = 3'd2
    } alu_op_e;

    localparam logic [16:0] OP_ADD_W   = 17'h00020;
    localparam logic [16:0] OP_SUB_W   = 17'h00022;
    localparam logic [9:0]  OP_ADDI_W  = 10'h00a;
    localparam logic [9:0]  OP_LD_W    = 10'h0a2;
    localparam logic [9:0]  OP_ST_W    = 10'h0a6;
    localparam logic [6:0]  OP_LU12I_W = 7'h0a;
    localparam logic [5:0]  OP_JIRL    = 6'h13;
    localparam logic [5:0]  OP_B       = 6'h14;
    localparam logic [5:0]  OP_BL      = 6'h15;
    localparam logic [5:0]  OP_BEQ     = 6'h16;
    localparam logic [5:0]  OP_BNE     = 6'h17;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] st_data;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_we;
        logic        res_from_mem;
        logic [31:0] pc;
    } ds_es_t;

    typedef struct packed {
        logic        valid;
        logic        is_load;
        logic [4:0]  dest;
        logic [31:0] result;
    } es_fwd_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_fwd_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ws_rf_t;

    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_t;

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 GPR file, two async read ports and one write port; r0 reads as zero.
// A read of the address being written this cycle returns the incoming write data.
module id_stage_regfile (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (we && (waddr == raddr1)) rdata1 = wdata;
        if (we && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == 5'd0) rdata1 = '0;
        if (raddr2 == 5'd0) rdata2 = '0;
    end

endmodule

// File: rtl/id_stage.sv
// LA32R decode: one-entry stage, resolves branches combinationally, stalls on hazards via ds_ready_go.
// DS_FORWARD_EN enables EX/MEM bypass (only load-use stalls); otherwise any EX/MEM dest match stalls.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     fs_to_ds_valid,
    input  logic [FS_DS_BUS_WD-1:0]  fs_ds_bus,
    output logic                     ds_allow_in,
    output logic [BR_BUS_WD-1:0]     br_bus,
    input  logic                     es_allow_in,
    output logic                     ds_to_es_valid,
    output logic [DS_ES_BUS_WD-1:0]  ds_es_bus,
    input  logic [ES_FWD_BUS_WD-1:0] es_fwd_bus,
    input  logic [MS_FWD_BUS_WD-1:0] ms_fwd_bus,
    input  logic [WS_RF_BUS_WD-1:0]  ws_rf_bus
);

    logic                    ds_valid_q, ds_valid_d;
    logic [FS_DS_BUS_WD-1:0] fs_ds_bus_q, fs_ds_bus_d;

    es_fwd_t es_fwd;
    ms_fwd_t ms_fwd;
    ws_rf_t  ws_rf;
    ds_es_t  uop;
    br_t     br;

    assign es_fwd = es_fwd_bus;
    assign ms_fwd = ms_fwd_bus;
    assign ws_rf  = ws_rf_bus;

    logic [31:0] pc, inst;
    logic [4:0]  rd, rj, rk, raddr2;
    assign pc   = fs_ds_bus_q[63:32];
    assign inst = fs_ds_bus_q[31:0];
    assign rd   = inst[4:0];
    assign rj   = inst[9:5];
    assign rk   = inst[14:10];

    logic op_add, op_sub, op_addi, op_ld, op_st, op_lu12i;
    logic op_jirl, op_b, op_bl, op_beq, op_bne;
    assign op_add   = inst[31:15] == OP_ADD_W;
    assign op_sub   = inst[31:15] == OP_SUB_W;
    assign op_addi  = inst[31:22] == OP_ADDI_W;
    assign op_ld    = inst[31:22] == OP_LD_W;
    assign op_st    = inst[31:22] == OP_ST_W;
    assign op_lu12i = inst[31:25] == OP_LU12I_W;
    assign op_jirl  = inst[31:26] == OP_JIRL;
    assign op_b     = inst[31:26] == OP_B;
    assign op_bl    = inst[31:26] == OP_BL;
    assign op_beq   = inst[31:26] == OP_BEQ;
    assign op_bne   = inst[31:26] == OP_BNE;

    logic r2_is_rd, use_rj, use_r2, is_branch;
    assign r2_is_rd  = op_st | op_beq | op_bne;
    assign use_rj    = op_add | op_sub | op_addi | op_ld | op_st | op_beq | op_bne | op_jirl;
    assign use_r2    = op_add | op_sub | r2_is_rd;
    assign is_branch = op_jirl | op_b | op_bl | op_beq | op_bne;
    assign raddr2    = r2_is_rd ? rd : rk;

    logic [31:0] si12, si20, offs16, offs26;
    assign si12   = {{20{inst[21]}}, inst[21:10]};
    assign si20   = {inst[24:5], 12'b0};
    assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b0};
    assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b0};

    logic [31:0] rf_rdata1, rf_rdata2;

    id_stage_regfile u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .raddr1 (rj),
        .rdata1 (rf_rdata1),
        .raddr2 (raddr2),
        .rdata2 (rf_rdata2),
        .we     (ws_rf.we),
        .waddr  (ws_rf.waddr),
        .wdata  (ws_rf.wdata)
    );

    // r0 never matches, so an unused or zero source can never stall.
    logic es_hit1, es_hit2, ms_hit1, ms_hit2, stall;
    logic [31:0] rj_val, r2_val;
    assign es_hit1 = use_rj & (rj != 5'd0) & es_fwd.valid & (es_fwd.dest == rj);
    assign es_hit2 = use_r2 & (raddr2 != 5'd0) & es_fwd.valid & (es_fwd.dest == raddr2);
    assign ms_hit1 = use_rj & (rj != 5'd0) & ms_fwd.valid & (ms_fwd.dest == rj);
    assign ms_hit2 = use_r2 & (raddr2 != 5'd0) & ms_fwd.valid & (ms_fwd.dest == raddr2);

`ifdef DS_FORWARD_EN
    assign stall  = (es_hit1 | es_hit2) & es_fwd.is_load;
    assign rj_val = es_hit1 ? es_fwd.result : (ms_hit1 ? ms_fwd.result : rf_rdata1);
    assign r2_val = es_hit2 ? es_fwd.result : (ms_hit2 ? ms_fwd.result : rf_rdata2);
`else
    logic unused_fwd;
    assign unused_fwd = ^{es_fwd.is_load, es_fwd.result, ms_fwd.result};
    assign stall  = es_hit1 | es_hit2 | ms_hit1 | ms_hit2;
    assign rj_val = rf_rdata1;
    assign r2_val = rf_rdata2;
`endif

    logic ds_ready_go, br_cond, br_taken;
    logic [31:0] br_tgt;
    assign ds_ready_go    = ~stall;
    assign ds_allow_in    = ~ds_valid_q | (ds_ready_go & es_allow_in);
    assign ds_to_es_valid = ds_valid_q & ds_ready_go;

    assign br_cond  = op_jirl | op_b | op_bl | (op_beq & (rj_val == r2_val)) | (op_bne & (rj_val != r2_val));
    assign br_tgt   = op_jirl ? (rj_val + offs16) : ((op_b | op_bl) ? (pc + offs26) : (pc + offs16));
    assign br_taken = ds_valid_q & ds_ready_go & es_allow_in & br_cond;

    always_comb begin
        br        = '0;
        br.stall  = ds_valid_q & is_branch & ~ds_ready_go;
        br.taken  = br_taken;
        br.target = br_taken ? br_tgt : 32'd0;
    end
    assign br_bus = br;

    always_comb begin
        uop              = '0;
        uop.alu_op       = ALU_ADD;
        uop.src1         = rj_val;
        uop.src2         = r2_val;
        uop.st_data      = r2_val;
        uop.dest         = rd;
        uop.pc           = pc;
        uop.mem_we       = op_st;
        uop.res_from_mem = op_ld;
        if (op_sub) uop.alu_op = ALU_SUB;
        if (op_lu12i) begin
            uop.alu_op = ALU_PASSB;
            uop.src2   = si20;
        end
        if (op_addi | op_ld | op_st) uop.src2 = si12;
        // Link ops compute pc+4 in EX; the jump target itself is resolved here.
        if (op_bl | op_jirl) begin
            uop.src1 = pc;
            uop.src2 = 32'd4;
        end
        if (op_bl) uop.dest = 5'd1;
        uop.gr_we = (op_add | op_sub | op_addi | op_ld | op_lu12i | op_bl | op_jirl) & (uop.dest != 5'd0);
    end
    assign ds_es_bus = uop;

    // A fetch arriving while a taken branch leaves is wrong-path and is dropped.
    always_comb begin
        ds_valid_d  = ds_valid_q;
        fs_ds_bus_d = fs_ds_bus_q;
        if (ds_allow_in) ds_valid_d = fs_to_ds_valid & ~br_taken;
        if (ds_allow_in & fs_to_ds_valid) fs_ds_bus_d = fs_ds_bus;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_q  <= 1'b0;
            fs_ds_bus_q <= '0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            fs_ds_bus_q <= fs_ds_bus_d;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Decode-stage bench: directed scenarios plus randomized instructions checked against an op-level model.
module tb_id_stage;
    import id_stage_pkg::*;

`ifdef DS_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef enum int {I_ADD, I_SUB, I_ADDI, I_LD, I_ST, I_LU12I, I_JIRL, I_B, I_BL, I_BEQ, I_BNE, I_NOP} op_e;

    logic         clk = 1'b0;
    logic         resetn, fs_to_ds_valid, ds_allow_in, es_allow_in, ds_to_es_valid;
    logic [63:0]  fs_ds_bus;
    logic [33:0]  br_bus;
    logic [138:0] ds_es_bus;
    logic [38:0]  es_fwd_bus;
    logic [37:0]  ms_fwd_bus, ws_rf_bus;

    int total = 0;
    int bad = 0;
    logic [31:0] regs [32];

    ds_es_t uop;
    br_t    br;
    assign uop = ds_es_bus;
    assign br  = br_bus;

    id_stage dut (
        .clk(clk), .resetn(resetn), .fs_to_ds_valid(fs_to_ds_valid), .fs_ds_bus(fs_ds_bus),
        .ds_allow_in(ds_allow_in), .br_bus(br_bus), .es_allow_in(es_allow_in),
        .ds_to_es_valid(ds_to_es_valid), .ds_es_bus(ds_es_bus), .es_fwd_bus(es_fwd_bus),
        .ms_fwd_bus(ms_fwd_bus), .ws_rf_bus(ws_rf_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural register state advances only on a clocked WB write.
    task automatic tick();
        @(posedge clk);
        if (resetn && ws_rf_bus[37] && ws_rf_bus[36:32] != 5'd0) regs[ws_rf_bus[36:32]] = ws_rf_bus[31:0];
        #1;
    endtask

    task automatic idle();
        fs_to_ds_valid = 1'b0;
        es_fwd_bus = '0;
        ms_fwd_bus = '0;
        ws_rf_bus = '0;
        es_allow_in = 1'b1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        idle();
        ws_rf_bus = {1'b1, a, d};
        tick();
        ws_rf_bus = '0;
    endtask

    // Drain decode, then hand it one instruction; it sits in decode when this returns.
    task automatic load(input logic [31:0] pc, input logic [31:0] inst, input bit rand_wb);
        idle();
        if (rand_wb) ws_rf_bus = {$urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 32'($urandom)};
        tick();
        ws_rf_bus = '0;
        fs_to_ds_valid = 1'b1;
        fs_ds_bus = {pc, inst};
        tick();
        fs_to_ds_valid = 1'b0;
    endtask

    function automatic logic [31:0] enc(input op_e op, input logic [4:0] rd, rj, rk, input logic [25:0] imm);
        case (op)
            I_ADD:   return {17'h00020, rk, rj, rd};
            I_SUB:   return {17'h00022, rk, rj, rd};
            I_ADDI:  return {10'h00a, imm[11:0], rj, rd};
            I_LD:    return {10'h0a2, imm[11:0], rj, rd};
            I_ST:    return {10'h0a6, imm[11:0], rj, rd};
            I_LU12I: return {7'h0a, imm[19:0], rd};
            I_JIRL:  return {6'h13, imm[15:0], rj, rd};
            I_B:     return {6'h14, imm[15:0], imm[25:16]};
            I_BL:    return {6'h15, imm[15:0], imm[25:16]};
            I_BEQ:   return {6'h16, imm[15:0], rj, rd};
            I_BNE:   return {6'h17, imm[15:0], rj, rd};
            default: return 32'h03400000;
        endcase
    endfunction

    function automatic logic [31:0] rfv(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (ws_rf_bus[37] && ws_rf_bus[36:32] == a) return ws_rf_bus[31:0];
        return regs[a];
    endfunction

    task automatic opnd(input bit used, input logic [4:0] a, output logic [31:0] v, inout bit st);
        bit eh, mh;
        eh = used && a != 5'd0 && es_fwd_bus[38] && es_fwd_bus[36:32] == a;
        mh = used && a != 5'd0 && ms_fwd_bus[37] && ms_fwd_bus[36:32] == a;
        if (FWD) begin
            st = st | (eh && es_fwd_bus[37]);
            v = eh ? es_fwd_bus[31:0] : (mh ? ms_fwd_bus[31:0] : rfv(a));
        end else begin
            st = st | eh | mh;
            v = rfv(a);
        end
    endtask

    task automatic model_check(input string tag, input op_e op, input logic [4:0] rd, rj, rk,
                               input logic [25:0] imm, input logic [31:0] pc);
        bit u1, u2, st, cond, taken, wr;
        logic [31:0] v1, v2, o16, o26, tgt;
        logic [4:0] dst;
        u1 = op inside {I_ADD, I_SUB, I_ADDI, I_LD, I_ST, I_BEQ, I_BNE, I_JIRL};
        u2 = op inside {I_ADD, I_SUB, I_ST, I_BEQ, I_BNE};
        st = 1'b0;
        opnd(u1, rj, v1, st);
        opnd(u2, (op inside {I_ADD, I_SUB}) ? rk : rd, v2, st);
        o16 = {{16{imm[15]}}, imm[15:0]} << 2;
        o26 = {{6{imm[25]}}, imm} << 2;
        cond = (op inside {I_JIRL, I_B, I_BL}) || (op == I_BEQ && v1 == v2) || (op == I_BNE && v1 != v2);
        tgt = (op == I_JIRL) ? v1 + o16 : ((op inside {I_B, I_BL}) ? pc + o26 : pc + o16);
        taken = !st && es_allow_in && cond;
        chk({tag, ".vld"}, ds_to_es_valid, !st);
        chk({tag, ".ain"}, ds_allow_in, !st && es_allow_in);
        chk({tag, ".brtk"}, br.taken, taken);
        chk({tag, ".brst"}, br.stall, (op inside {I_JIRL, I_B, I_BL, I_BEQ, I_BNE}) && st);
        chk({tag, ".brtg"}, br.target, taken ? tgt : 32'd0);
        if (!st) begin
            dst = (op == I_BL) ? 5'd1 : rd;
            wr = (op inside {I_ADD, I_SUB, I_ADDI, I_LD, I_LU12I, I_BL, I_JIRL}) && dst != 5'd0;
            chk({tag, ".we"}, uop.gr_we, wr);
            chk({tag, ".mwe"}, uop.mem_we, op == I_ST);
            chk({tag, ".pc"}, uop.pc, pc);
            if (op != I_NOP) chk({tag, ".rfm"}, uop.res_from_mem, op == I_LD);
            if (wr) chk({tag, ".dst"}, uop.dest, dst);
            case (op)
                I_ADD, I_SUB: begin
                    chk({tag, ".s1"}, uop.src1, v1);
                    chk({tag, ".s2"}, uop.src2, v2);
                    chk({tag, ".alu"}, uop.alu_op, (op == I_SUB) ? 32'd1 : 32'd0);
                end
                I_ADDI, I_LD, I_ST: begin
                    chk({tag, ".s1"}, uop.src1, v1);
                    chk({tag, ".s2"}, uop.src2, {{20{imm[11]}}, imm[11:0]});
                    chk({tag, ".alu"}, uop.alu_op, 32'd0);
                    if (op == I_ST) chk({tag, ".std"}, uop.st_data, v2);
                end
                I_LU12I: begin
                    chk({tag, ".s2"}, uop.src2, {12'd0, imm[19:0]} << 12);
                    chk({tag, ".alu"}, uop.alu_op, 32'd2);
                end
                I_BL, I_JIRL: begin
                    chk({tag, ".s1"}, uop.src1, pc);
                    chk({tag, ".s2"}, uop.src2, 32'd4);
                    chk({tag, ".alu"}, uop.alu_op, 32'd0);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        op_e op;
        logic [4:0]  rd, rj, rk;
        logic [25:0] imm;
        logic [31:0] pc;

        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        resetn = 1'b0;
        idle();
        fs_ds_bus = '0;
        #3;
        chk("rst.vld", ds_to_es_valid, 1'b0);
        chk("rst.ain", ds_allow_in, 1'b1);
        chk("rst.brtk", br.taken, 1'b0);
        chk("rst.brst", br.stall, 1'b0);
        chk("rst.brtg", br.target, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        for (int a = 1; a < 32; a++) wb(5'(a), $urandom);

        // add.w r3,r1,r2
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);
        load(32'h1c000100, enc(I_ADD, 5'd3, 5'd1, 5'd2, 26'd0), 1'b0);
        #1;
        chk("t1.s1", uop.src1, 32'd5);
        chk("t1.s2", uop.src2, 32'd7);
        chk("t1.dst", uop.dest, 32'd3);
        chk("t1.we", uop.gr_we, 1'b1);
        chk("t1.alu", uop.alu_op, 32'd0);

        // taken beq drops the following fetch
        load(32'h1c000000, enc(I_BEQ, 5'd1, 5'd1, 5'd0, 26'd4), 1'b0);
        fs_to_ds_valid = 1'b1;
        fs_ds_bus = {32'h1c000004, enc(I_ADD, 5'd5, 5'd1, 5'd2, 26'd0)};
        #1;
        chk("t2.brtk", br.taken, 1'b1);
        chk("t2.brtg", br.target, 32'h1c000010);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("t2.drop", ds_to_es_valid, 1'b0);

        // load-use on bne r4,r0
        pc = 32'h1c000200;
        load(pc, enc(I_BNE, 5'd0, 5'd4, 5'd0, 26'd8), 1'b0);
        es_fwd_bus = {1'b1, 1'b1, 5'd4, 32'hdead0000};
        #1;
        chk("t3.brst", br.stall, 1'b1);
        chk("t3.brtk", br.taken, 1'b0);
        chk("t3.ain", ds_allow_in, 1'b0);
        tick();
        #1;
        chk("t3.brst2", br.stall, 1'b1);
        es_fwd_bus = '0;
        ms_fwd_bus = {1'b1, 5'd4, 32'h55};
        #1;
        chk("t3.ms_tk", br.taken, FWD);
        chk("t3.ms_st", br.stall, !FWD);
        tick();
        ms_fwd_bus = '0;
        ws_rf_bus = {1'b1, 5'd4, 32'h55};
        #1;
        chk("t3.wb_tk", br.taken, !FWD);
        chk("t3.wb_tg", br.target, FWD ? 32'd0 : pc + 32'd32);
        tick();
        ws_rf_bus = '0;

        // EX backpressure holds the uop and the branch
        pc = 32'h1c000300;
        load(pc, enc(I_BEQ, 5'd2, 5'd2, 5'd0, 26'd3), 1'b0);
        es_allow_in = 1'b0;
        fs_to_ds_valid = 1'b1;
        fs_ds_bus = {pc + 32'd4, enc(I_NOP, 5'd0, 5'd0, 5'd0, 26'd0)};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4.ain", ds_allow_in, 1'b0);
            chk("t4.vld", ds_to_es_valid, 1'b1);
            chk("t4.brtk", br.taken, 1'b0);
            chk("t4.pc", uop.pc, pc);
            tick();
        end
        es_allow_in = 1'b1;
        #1;
        chk("t4.rel_tk", br.taken, 1'b1);
        chk("t4.rel_tg", br.target, pc + 32'd12);
        tick();
        fs_to_ds_valid = 1'b0;

        // EX and MEM both target r2
        load(32'h1c000400, enc(I_ADD, 5'd3, 5'd2, 5'd0, 26'd0), 1'b0);
        es_allow_in = 1'b0;
        es_fwd_bus = {1'b1, 1'b0, 5'd2, 32'haa};
        ms_fwd_bus = {1'b1, 5'd2, 32'hbb};
        #1;
        chk("t5.vld1", ds_to_es_valid, FWD);
        chk("t5.s1", uop.src1 & {32{ds_to_es_valid}}, FWD ? 32'haa : 32'd0);
        tick();
        es_fwd_bus = '0;
        #1;
        chk("t5.vld2", ds_to_es_valid, FWD);
        tick();
        ms_fwd_bus = '0;
        ws_rf_bus = {1'b1, 5'd2, 32'h77};
        #1;
        chk("t5.vld3", ds_to_es_valid, 1'b1);
        chk("t5.rf", uop.src1, 32'h77);
        tick();

        for (int n = 0; n < 300; n++) begin
            op  = op_e'($urandom_range(0, 11));
            rd  = 5'($urandom_range(0, 7));
            rj  = 5'($urandom_range(0, 7));
            rk  = 5'($urandom_range(0, 7));
            imm = 26'($urandom);
            pc  = $urandom & 32'hfffffffc;
            load(pc, enc(op, rd, rj, rk, imm), 1'b1);
            es_fwd_bus  = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 32'($urandom)};
            ms_fwd_bus  = {$urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 32'($urandom)};
            ws_rf_bus   = {$urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 32'($urandom)};
            es_allow_in = $urandom_range(0, 3) != 0;
            #1;
            model_check("rnd", op, rd, rj, rk, imm, pc);
        end

        // reset while a taken branch sits in decode
        load(32'h1c000500, enc(I_B, 5'd0, 5'd0, 5'd0, 26'h40), 1'b0);
        #1;
        chk("t6.pre_tk", br.taken, 1'b1);
        #2;
        resetn = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        #1;
        chk("t6.brtk", br.taken, 1'b0);
        chk("t6.brtg", br.target, 32'd0);
        chk("t6.vld", ds_to_es_valid, 1'b0);
        chk("t6.ain", ds_allow_in, 1'b1);
        tick();
        resetn = 1'b1;
        load(32'h1c000600, enc(I_ADD, 5'd3, 5'd1, 5'd2, 26'd0), 1'b0);
        #1;
        chk("t6.vld2", ds_to_es_valid, 1'b1);
        chk("t6.s1", uop.src1, 32'd0);
        chk("t6.s2", uop.src2, 32'd0);
        chk("t6.dst", uop.dest, 32'd3);
        chk("t6.we", uop.gr_we, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
